// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush controller with wrong-path fetch drop and perf counters
module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic [4:0]       rdE,
    input  logic             memReadE,
    input  logic             pcSrcE,
    input  logic             imem_ready,
    input  logic             dmem_busy,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushW,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [CNT_W-1:0] fetch_wait_cnt
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        DROP = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_next_state;
    logic             w_load_use;
    logic             w_redirect;
    logic             w_fetch_wait;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_redirect_cnt;
    logic [CNT_W-1:0] r_fetch_wait_cnt;

    assign w_load_use = memReadE && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // First matching rule wins; reset forces every control low so the datapath sees no stalls.
    always_comb begin
        stallF       = 1'b0;
        stallD       = 1'b0;
        stallE       = 1'b0;
        stallM       = 1'b0;
        flushD       = 1'b0;
        flushE       = 1'b0;
        flushW       = 1'b0;
        w_redirect   = 1'b0;
        w_fetch_wait = 1'b0;
        w_next_state = r_state;
        if (reset) begin
            w_next_state = RUN;
        end else if (dmem_busy) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end else if (pcSrcE) begin
            flushD       = 1'b1;
            flushE       = 1'b1;
            w_redirect   = 1'b1;
            // An outstanding fetch still belongs to the old PC and must be discarded on arrival.
            w_next_state = imem_ready ? RUN : DROP;
        end else if (r_state == DROP) begin
            stallF = 1'b1;
            flushD = 1'b1;
            if (imem_ready) begin
                w_next_state = RUN;
            end
        end else if (w_load_use) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end else if (!imem_ready) begin
            stallF       = 1'b1;
            flushD       = 1'b1;
            w_fetch_wait = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt      <= '0;
            r_redirect_cnt   <= '0;
            r_fetch_wait_cnt <= '0;
        end else begin
            if (stallF && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (w_redirect && (r_redirect_cnt != CNT_MAX)) begin
                r_redirect_cnt <= r_redirect_cnt + CNT_ONE;
            end
            if (w_fetch_wait && (r_fetch_wait_cnt != CNT_MAX)) begin
                r_fetch_wait_cnt <= r_fetch_wait_cnt + CNT_ONE;
            end
        end
    end

    assign stall_cnt      = r_stall_cnt;
    assign redirect_cnt   = r_redirect_cnt;
    assign fetch_wait_cnt = r_fetch_wait_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  rs1D;
    logic [4:0]  rs2D;
    logic [4:0]  rdE;
    logic        memReadE;
    logic        pcSrcE;
    logic        imem_ready;
    logic        dmem_busy;

    logic        stallF, stallD, stallE, stallM, flushD, flushE, flushW;
    logic [31:0] stall_cnt, redirect_cnt, fetch_wait_cnt;

    logic        stallF4, stallD4, stallE4, stallM4, flushD4, flushE4, flushW4;
    logic [3:0]  stall_cnt4, redirect_cnt4, fetch_wait_cnt4;

    int total;
    int bad;

    // Output vector order: {stallF, stallD, stallE, stallM, flushD, flushE, flushW}
    localparam logic [6:0] O_IDLE   = 7'b0000000;
    localparam logic [6:0] O_LU     = 7'b1100010;
    localparam logic [6:0] O_REDIR  = 7'b0000110;
    localparam logic [6:0] O_DROP   = 7'b1000100;
    localparam logic [6:0] O_FWAIT  = 7'b1000100;
    localparam logic [6:0] O_FREEZE = 7'b1111001;

    hazard_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .rs1D           (rs1D),
        .rs2D           (rs2D),
        .rdE            (rdE),
        .memReadE       (memReadE),
        .pcSrcE         (pcSrcE),
        .imem_ready     (imem_ready),
        .dmem_busy      (dmem_busy),
        .stallF         (stallF),
        .stallD         (stallD),
        .stallE         (stallE),
        .stallM         (stallM),
        .flushD         (flushD),
        .flushE         (flushE),
        .flushW         (flushW),
        .stall_cnt      (stall_cnt),
        .redirect_cnt   (redirect_cnt),
        .fetch_wait_cnt (fetch_wait_cnt)
    );

    hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk            (clk),
        .reset          (reset),
        .rs1D           (rs1D),
        .rs2D           (rs2D),
        .rdE            (rdE),
        .memReadE       (memReadE),
        .pcSrcE         (pcSrcE),
        .imem_ready     (imem_ready),
        .dmem_busy      (dmem_busy),
        .stallF         (stallF4),
        .stallD         (stallD4),
        .stallE         (stallE4),
        .stallM         (stallM4),
        .flushD         (flushD4),
        .flushE         (flushE4),
        .flushW         (flushW4),
        .stall_cnt      (stall_cnt4),
        .redirect_cnt   (redirect_cnt4),
        .fetch_wait_cnt (fetch_wait_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {stallF, stallD, stallE, stallM, flushD, flushE, flushW};
    endfunction

    function automatic logic [6:0] outs4();
        return {stallF4, stallD4, stallE4, stallM4, flushD4, flushE4, flushW4};
    endfunction

    task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                         input logic [4:0] r2, input logic pc, input logic ir, input logic db);
        memReadE   = mr;
        rdE        = rd;
        rs1D       = r1;
        rs2D       = r2;
        pcSrcE     = pc;
        imem_ready = ir;
        dmem_busy  = db;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_outs", {25'd0, outs()}, {25'd0, O_IDLE});
        check("reset_stall_cnt", stall_cnt, 32'd0);
        check("reset_redir_cnt", redirect_cnt, 32'd0);
        check("reset_fwait_cnt", fetch_wait_cnt, 32'd0);
        reset = 1'b0;

        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        check("idle_outs", {25'd0, outs()}, {25'd0, O_IDLE});
        step();

        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0);
        check("lu_outs", {25'd0, outs()}, {25'd0, O_LU});
        step();
        check("lu_stall_cnt", stall_cnt, 32'd1);

        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        check("lu_rd0_outs", {25'd0, outs()}, {25'd0, O_IDLE});
        step();
        check("lu_rd0_stall_cnt", stall_cnt, 32'd1);

        drive(1'b1, 5'd7, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
        check("br_over_lu_outs", {25'd0, outs()}, {25'd0, O_REDIR});
        step();
        check("br_over_lu_redir", redirect_cnt, 32'd1);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        check("br_then_run", {25'd0, outs()}, {25'd0, O_IDLE});
        step();

        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        check("redir_wait_outs", {25'd0, outs()}, {25'd0, O_REDIR});
        step();
        check("redir_wait_redir", redirect_cnt, 32'd2);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, (i == 2), 1'b0);
            check($sformatf("drop_%0d_outs", i), {25'd0, outs()}, {25'd0, O_DROP});
            step();
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        check("after_drop_outs", {25'd0, outs()}, {25'd0, O_IDLE});
        check("after_drop_stall_cnt", stall_cnt, 32'd4);
        check("after_drop_fwait_cnt", fetch_wait_cnt, 32'd0);
        step();

        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
            check($sformatf("freeze_%0d_outs", i), {25'd0, outs()}, {25'd0, O_FREEZE});
            step();
            check($sformatf("freeze_%0d_redir", i), redirect_cnt, 32'd2);
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        check("unfreeze_outs", {25'd0, outs()}, {25'd0, O_REDIR});
        step();
        check("unfreeze_redir", redirect_cnt, 32'd3);
        check("unfreeze_stall_cnt", stall_cnt, 32'd7);

        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        step();
        check("drop2_redir", redirect_cnt, 32'd4);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        check("drop_freeze_outs", {25'd0, outs()}, {25'd0, O_FREEZE});
        step();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("drop_kept_outs", {25'd0, outs()}, {25'd0, O_DROP});
        check("drop_kept_stall_cnt", stall_cnt, 32'd8);

        #2;
        reset = 1'b1;
        #1;
        check("midreset_outs", {25'd0, outs()}, {25'd0, O_IDLE});
        check("midreset_stall_cnt", stall_cnt, 32'd0);
        check("midreset_redir_cnt", redirect_cnt, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        check("postreset_run_outs", {25'd0, outs()}, {25'd0, O_IDLE});
        step();

        drive(1'b1, 5'd3, 5'd0, 5'd3, 1'b0, 1'b1, 1'b1);
        check("lu_freeze_outs", {25'd0, outs()}, {25'd0, O_FREEZE});
        step();

        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
            if (i == 0) begin
                check("fwait_outs", {25'd0, outs()}, {25'd0, O_FWAIT});
                check("fwait_outs4", {25'd0, outs4()}, {25'd0, O_FWAIT});
            end
            step();
        end
        check("sat_fwait4", {28'd0, fetch_wait_cnt4}, 32'd15);
        check("sat_stall4", {28'd0, stall_cnt4}, 32'd15);
        check("sat_redir4", {28'd0, redirect_cnt4}, 32'd0);
        check("wide_fwait", fetch_wait_cnt, 32'd20);
        check("wide_stall", stall_cnt, 32'd21);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
